// File: rtl/handshake_cond_br_cfifo_pkg.sv
// Shared helpers for the conditional branch with condition FIFO:
// sizing functions and handshake-stability assertion macro.
package handshake_cond_br_cfifo_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic bit depth_ok(input int d);
      return (d >= 2) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// Producer must hold valid and payload stable until ready is seen.
`ifndef HS_HOLD
`define HS_HOLD(clk_, rst_, v_, r_, d_) \
   assert property (@(posedge clk_) disable iff (rst_) \
      ((v_) && !(r_)) |=> ((v_) && $stable(d_)))
`endif

// File: rtl/handshake_cond_br_cfifo_cond_fifo.sv
// 1-bit synchronous condition FIFO with registered empty/full flags;
// a pushed bit reaches the head one cycle later, never combinationally.
module cond_fifo_1b
   import handshake_cond_br_cfifo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ins,
   input  logic ins_valid,
   output logic ins_ready,
   output logic outs,
   output logic outs_valid,
   input  logic outs_ready
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("cond_fifo_1b: DEPTH must be a power of two >= 2");
   end

   logic [DEPTH-1:0] r_mem;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_empty;
   logic             r_full;

   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_count_nxt;

   // Full blocks a push even when a pop frees a slot this cycle.
   assign ins_ready  = ~rst & ~r_full;
   assign outs_valid = ~r_empty;
   assign outs       = r_mem[r_rd_ptr];

   assign w_push = ins_valid & ins_ready;
   assign w_pop  = outs_valid & outs_ready;

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= ins;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == FULL_CNT);
      end
   end

   a_count_bound : assert property (
      @(posedge clk) disable iff (rst) r_count <= FULL_CNT);

   a_flags : assert property (
      @(posedge clk) disable iff (rst)
      (r_empty == (r_count == '0)) && (r_full == (r_count == FULL_CNT)));

endmodule

// File: rtl/handshake_cond_br_cfifo.sv
// Conditional branch: steers each data token to trueOut or falseOut
// by the oldest buffered compare result.
module handshake_cond_br_cfifo
   import handshake_cond_br_cfifo_pkg::*;
#(
   parameter int DATA_TYPE = 32,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 condition,
   input  logic                 condition_valid,
   output logic                 condition_ready,
   input  logic [DATA_TYPE-1:0] data,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [DATA_TYPE-1:0] trueOut,
   output logic                 trueOut_valid,
   input  logic                 trueOut_ready,
   output logic [DATA_TYPE-1:0] falseOut,
   output logic                 falseOut_valid,
   input  logic                 falseOut_ready
);

   logic w_head;
   logic w_head_valid;
   logic w_nonempty;
   logic w_take;
   logic w_sel_ready;

   cond_fifo_1b #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .ins        (condition),
      .ins_valid  (condition_valid),
      .ins_ready  (condition_ready),
      .outs       (w_head),
      .outs_valid (w_head_valid),
      .outs_ready (data_ready)
   );

   // Stale entries must not leak out during the reset cycle.
   assign w_nonempty = ~rst & w_head_valid;
   assign w_take     = w_nonempty & data_valid;

   assign trueOut_valid  = w_take &  w_head;
   assign falseOut_valid = w_take & ~w_head;

   assign w_sel_ready = w_head ? trueOut_ready : falseOut_ready;
   assign data_ready  = w_take & w_sel_ready;

   assign trueOut  = data;
   assign falseOut = data;

   a_cond_hold : `HS_HOLD(clk, rst, condition_valid, condition_ready, condition);
   a_data_hold : `HS_HOLD(clk, rst, data_valid, data_ready, data);

   a_one_hot : assert property (
      @(posedge clk) !(trueOut_valid && falseOut_valid));

endmodule

// File: tb/tb_handshake_cond_br_cfifo.sv
// Directed table-driven bench for handshake_cond_br_cfifo,
// plus a scoreboard sequence for simultaneous push/pop.
module tb_handshake_cond_br_cfifo;

   typedef struct {
      logic        rst;
      logic        c;
      logic        cv;
      logic [31:0] d;
      logic        dv;
      logic        tr;
      logic        fr;
      logic        e_cr;
      logic        e_tv;
      logic        e_fv;
      logic        e_dr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        condition = 1'b0;
   logic        condition_valid = 1'b0;
   logic        condition_ready;
   logic [31:0] data = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [31:0] trueOut;
   logic        trueOut_valid;
   logic        trueOut_ready = 1'b1;
   logic [31:0] falseOut;
   logic        falseOut_valid;
   logic        falseOut_ready = 1'b1;

   int   n_pass = 0;
   int   n_total = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   handshake_cond_br_cfifo #(
      .DATA_TYPE (32),
      .DEPTH     (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .condition       (condition),
      .condition_valid (condition_valid),
      .condition_ready (condition_ready),
      .data            (data),
      .data_valid      (data_valid),
      .data_ready      (data_ready),
      .trueOut         (trueOut),
      .trueOut_valid   (trueOut_valid),
      .trueOut_ready   (trueOut_ready),
      .falseOut        (falseOut),
      .falseOut_valid  (falseOut_valid),
      .falseOut_ready  (falseOut_ready)
   );

   task automatic v(input logic r, input logic c, input logic cv,
                    input logic [31:0] d, input logic dv,
                    input logic tr, input logic fr,
                    input logic cr, input logic tv,
                    input logic fv, input logic dr);
      vec_t x;
      x.rst = r;  x.c = c;   x.cv = cv; x.d = d;   x.dv = dv;
      x.tr = tr;  x.fr = fr; x.e_cr = cr;
      x.e_tv = tv; x.e_fv = fv; x.e_dr = dr;
      vq.push_back(x);
   endtask

   task automatic run_vec(input vec_t x, input string nm);
      logic [3:0] got;
      logic [3:0] exp;
      @(negedge clk);
      rst             = x.rst;
      condition       = x.c;
      condition_valid = x.cv;
      data            = x.d;
      data_valid      = x.dv;
      trueOut_ready   = x.tr;
      falseOut_ready  = x.fr;
      #2;
      got = {condition_ready, trueOut_valid, falseOut_valid, data_ready};
      exp = {x.e_cr, x.e_tv, x.e_fv, x.e_dr};
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: cr/tv/fv/dr got %b required %b", nm, got, exp);
      if (x.e_tv) begin
         n_total++;
         if (trueOut === x.d) n_pass++;
         else $display("FAIL %s trueOut: got %h required %h", nm, trueOut, x.d);
      end
      if (x.e_fv) begin
         n_total++;
         if (falseOut === x.d) n_pass++;
         else $display("FAIL %s falseOut: got %h required %h", nm, falseOut, x.d);
      end
   endtask

   initial begin
      logic sb[$];
      vec_t x;
      logic c;
      logic h;

      // reset then idle
      v(1,0,0,32'h0 ,0,1,1, 0,0,0,0);
      v(1,0,0,32'h0 ,0,1,1, 0,0,0,0);
      v(0,0,0,32'h0 ,0,1,1, 1,0,0,0);
      // single token: visible one cycle after push
      v(0,1,1,32'h2A,1,1,1, 1,0,0,0);
      v(0,0,0,32'h2A,1,1,1, 1,1,0,1);
      v(0,0,0,32'h0 ,0,1,1, 1,0,0,0);
      // fill 1,0,1,0
      v(0,1,1,32'h0 ,0,1,1, 1,0,0,0);
      v(0,0,1,32'h0 ,0,1,1, 1,0,0,0);
      v(0,1,1,32'h0 ,0,1,1, 1,0,0,0);
      v(0,0,1,32'h0 ,0,1,1, 1,0,0,0);
      v(0,0,0,32'h0 ,0,1,1, 0,0,0,0);
      // drain; a condition offered while full must wait a cycle
      v(0,1,1,32'd10,1,1,1, 0,1,0,1);
      v(0,1,1,32'd11,1,1,1, 1,0,1,1);
      v(0,0,0,32'd12,1,1,1, 1,1,0,1);
      v(0,0,0,32'd13,1,1,1, 1,0,1,1);
      v(0,0,0,32'd14,1,1,1, 1,1,0,1);
      // empty with data held, push head=0
      v(0,0,1,32'd15,1,1,1, 1,0,0,0);
      // backpressure on the false path
      v(0,0,0,32'd15,1,1,0, 1,0,1,0);
      v(0,0,0,32'd15,1,1,0, 1,0,1,0);
      v(0,0,0,32'd15,1,1,0, 1,0,1,0);
      v(0,0,0,32'd15,1,1,1, 1,0,1,1);
      v(0,0,0,32'h0 ,0,1,1, 1,0,0,0);
      // reset mid-run with three true conditions buffered
      v(0,1,1,32'h0 ,0,1,1, 1,0,0,0);
      v(0,1,1,32'h0 ,0,1,1, 1,0,0,0);
      v(0,1,1,32'h0 ,0,1,1, 1,0,0,0);
      v(1,0,0,32'h77,1,1,1, 0,0,0,0);
      v(0,0,0,32'h77,1,1,1, 1,0,0,0);
      v(0,0,1,32'h77,1,1,1, 1,0,0,0);
      v(0,0,0,32'h77,1,1,1, 1,0,1,1);
      v(0,0,0,32'h0 ,0,1,1, 1,0,0,0);

      rst = 1'b1;
      @(posedge clk);
      foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

      // simultaneous push/pop at count=2 against a scoreboard
      for (int i = 0; i < 2; i++) begin
         c = 1'($urandom_range(0, 1));
         x = '{rst:0, c:c, cv:1, d:32'h0, dv:0, tr:1, fr:1,
               e_cr:1, e_tv:0, e_fv:0, e_dr:0};
         run_vec(x, $sformatf("prime%0d", i));
         sb.push_back(c);
      end
      for (int i = 0; i < 8; i++) begin
         c = 1'($urandom_range(0, 1));
         h = sb.pop_front();
         x = '{rst:0, c:c, cv:1, d:32'h100 + i, dv:1, tr:1, fr:1,
               e_cr:1, e_tv:h, e_fv:~h, e_dr:1};
         run_vec(x, $sformatf("pp%0d", i));
         sb.push_back(c);
      end
      for (int i = 0; i < 2; i++) begin
         h = sb.pop_front();
         x = '{rst:0, c:0, cv:0, d:32'h200 + i, dv:1, tr:1, fr:1,
               e_cr:1, e_tv:h, e_fv:~h, e_dr:1};
         run_vec(x, $sformatf("drain%0d", i));
      end
      x = '{rst:0, c:0, cv:0, d:32'h300, dv:1, tr:1, fr:1,
            e_cr:1, e_tv:0, e_fv:0, e_dr:0};
      run_vec(x, "empty_after_drain");

      @(negedge clk);
      data_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
